// File: rtl/ysyx_25030081_rf_pkg.sv
// Shared types and default widths for the multi-port register file.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
package ysyx_25030081_rf_pkg;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NR_RD      = 2;
  localparam int RF_NR_WR      = 1;

endpackage

// File: rtl/ysyx_25030081_rf_rdsel.sv
// One read port: zero-register masking, INIT masking and, with RF_BYPASS_EN,
// priority selection of the same-cycle write data over the stored entry.
module ysyx_25030081_rf_rdsel
  import ysyx_25030081_rf_pkg::*;
#(
`ifdef RF_BYPASS_EN
  parameter int NR_WR      = RF_NR_WR,
`endif
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ZERO_REG   = 1
) (
`ifdef RF_BYPASS_EN
  input  logic [NR_WR-1:0]            wen,
  input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NR_WR*DATA_WIDTH-1:0] wdata,
`endif
  input  logic                        rf_ready,
  input  logic [ADDR_WIDTH-1:0]       raddr,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  output logic [DATA_WIDTH-1:0]       rdata
);

  logic is_zero;

  assign is_zero = (ZERO_REG != 0) && (raddr == '0);

  always_comb begin
    rdata = mem_data;
`ifdef RF_BYPASS_EN
    // Ascending scan: the highest-indexed matching port wins, like the array write.
    for (int j = 0; j < NR_WR; j++) begin
      if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == raddr)) begin
        rdata = wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`endif
    if (!rf_ready || is_zero) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/ysyx_25030081_rf_mp.sv
// Multi-port register file that zero-sweeps every entry after reset before
// accepting writes. Define RF_BYPASS_EN for same-cycle write-to-read bypass.
module ysyx_25030081_rf_mp
  import ysyx_25030081_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NR_RD      = RF_NR_RD,
  parameter int NR_WR      = RF_NR_WR,
  parameter int ZERO_REG   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NR_RD*DATA_WIDTH-1:0] rdata,
  input  logic [NR_WR-1:0]            wen,
  input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NR_WR*DATA_WIDTH-1:0] wdata,
  output logic                        ready,
  output rf_state_e                   state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  rf_state_e             state_q;
  rf_state_e             state_d;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] init_cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RF_INIT;
      init_cnt <= '0;
    end else begin
      state_q  <= state_d;
      init_cnt <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt;
    case (state_q)
      RF_INIT: begin
        init_cnt_d = init_cnt + 1'b1;
        if (init_cnt == LAST_IDX) begin
          state_d = RF_READY;
        end
      end
      RF_READY: state_d = RF_READY;
      default:  state_d = RF_INIT;
    endcase
  end

  assign ready = (state_q == RF_READY);
  assign state = state_q;

  // The array has no reset: the sweep is what gives it defined contents.
  // Later loop iterations override earlier ones, so the highest port wins.
  always_ff @(posedge clk) begin
    if (state_q == RF_INIT) begin
      mem[init_cnt] <= '0;
    end else begin
      for (int j = 0; j < NR_WR; j++) begin
        if (wen[j] && !((ZERO_REG != 0) && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
          mem[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar i = 0; i < NR_RD; i++) begin : g_rd
    ysyx_25030081_rf_rdsel #(
`ifdef RF_BYPASS_EN
      .NR_WR      (NR_WR),
`endif
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rdsel (
`ifdef RF_BYPASS_EN
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
`endif
      .rf_ready (ready),
      .raddr    (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem_data (mem[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]]),
      .rdata    (rdata[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_ysyx_25030081_rf_mp.sv
// Bench for ysyx_25030081_rf_mp (two read ports, two write ports, zero register).
// Builds with or without RF_BYPASS_EN; the reference model follows the macro.
module tb_ysyx_25030081_rf_mp;
  import ysyx_25030081_rf_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR_RD = 2;
  localparam int NR_WR = 2;
  localparam int DEPTH = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NR_RD*AW-1:0]   raddr = '0;
  logic [NR_RD*DW-1:0]   rdata;
  logic [NR_WR-1:0]      wen = '0;
  logic [NR_WR*AW-1:0]   waddr = '0;
  logic [NR_WR*DW-1:0]   wdata = '0;
  logic                  ready;
  rf_state_e             state;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  ysyx_25030081_rf_mp #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NR_RD      (NR_RD),
    .NR_WR      (NR_WR),
    .ZERO_REG   (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raddr (raddr),
    .rdata (rdata),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .ready (ready),
    .state (state)
  );

  // reference model: cycles since reset release and a plain array of contents
  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
    end else if (m_cnt < DEPTH) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      end
    end else begin
      for (int j = 0; j < NR_WR; j++) begin
        if (wen[j] && waddr[j*AW +: AW] != 0) m_mem[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
      end
    end
  end

  function automatic logic m_ready();
    return !rst && (m_cnt == DEPTH);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!m_ready() || a == 0) return '0;
    v = m_mem[a];
`ifdef RF_BYPASS_EN
    for (int j = 0; j < NR_WR; j++) begin
      if (wen[j] && waddr[j*AW +: AW] == a) v = wdata[j*DW +: DW];
    end
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", DW'(ready), DW'(m_ready()));
      check("state", DW'(state), DW'(m_ready() ? RF_READY : RF_INIT));
      for (int i = 0; i < NR_RD; i++) begin
        check($sformatf("rdata%0d", i), rdata[i*DW +: DW], exp_rd(raddr[i*AW +: AW]));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[p] = en;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic read_chk(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    raddr[p*AW +: AW] = a;
    @(negedge clk);
    check(name, rdata[p*DW +: DW], exp);
  endtask

  logic [DW-1:0] exp_same;

  initial begin
    int n;
    rst = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    rst = 1'b0;
    wait_ready(n);
    check("init_latency", DW'(n), 32);

    // write then read entry 5, same cycle and next cycle
`ifdef RF_BYPASS_EN
    exp_same = 32'hDEADBEEF;
`else
    exp_same = 32'h0;
`endif
    set_wr(0, 1'b1, 5, 32'hDEADBEEF);
    read_chk(0, 5, exp_same, "wr5_same_cycle");
    step();
    set_wr(0, 1'b0, 0, 0);
    read_chk(0, 5, 32'hDEADBEEF, "wr5_next_cycle");

    // entry 0 stays zero
    step();
    set_wr(0, 1'b1, 0, 32'h1234);
    read_chk(0, 0, 32'h0, "zero_same_cycle");
    step();
    set_wr(0, 1'b0, 0, 0);
    read_chk(0, 0, 32'h0, "zero_after_write");

    // both ports hit entry 7: port 1 wins
`ifdef RF_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h0;
`endif
    step();
    set_wr(0, 1'b1, 7, 32'h11);
    set_wr(1, 1'b1, 7, 32'h22);
    read_chk(1, 7, exp_same, "collide_same_cycle");
    step();
    set_wr(0, 1'b0, 0, 0);
    set_wr(1, 1'b0, 0, 0);
    read_chk(1, 7, 32'h22, "collide_winner");

    // distinct addresses both commit
    step();
    set_wr(0, 1'b1, 10, 32'hA0A0);
    set_wr(1, 1'b1, 11, 32'hB1B1);
    step();
    set_wr(0, 1'b0, 0, 0);
    set_wr(1, 1'b0, 0, 0);
    raddr[1*AW +: AW] = 11;
    read_chk(0, 10, 32'hA0A0, "distinct_port0");
    check("distinct_port1", rdata[1*DW +: DW], 32'hB1B1);

    // asynchronous reset from READY, then a second reset mid-sweep
    step();
    rst = 1'b1;
    @(negedge clk);
    check("async_rst_ready", DW'(ready), 0);
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_wr(0, 1'b1, 3, 32'hFF);
    wait_ready(n);
    set_wr(0, 1'b0, 0, 0);
    check("restart_latency", DW'(n), 32);
    read_chk(0, 10, 32'h0, "swept_after_restart");
    read_chk(1, 3, 32'h0, "init_write_dropped");

    // randomized traffic with addresses biased toward collisions
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      for (int j = 0; j < NR_WR; j++) begin
        set_wr(j, 1'($urandom_range(0, 1)),
               AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1)),
               $urandom);
      end
      for (int i = 0; i < NR_RD; i++) begin
        raddr[i*AW +: AW] = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1));
      end
    end
    wen = '0;
    step();
    step();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_rf_mp.md
YSYX_25030081_RF_MP -- requirements
Module: ysyx_25030081_rf_mp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width; depth DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width.
REQ-003 SHALL have parameter NR_RD, default 2, read port count (1..8).
REQ-004 SHALL have parameter NR_WR, default 1, write port count (1..4).
REQ-005 SHALL have parameter ZERO_REG, default 1; 1 = entry 0 hardwired to zero.
REQ-006 SHALL have port clk, input, 1, sole clock; all state on posedge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port raddr, input, NR_RD*ADDR_WIDTH, packed read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port rdata, output, NR_RD*DATA_WIDTH, packed combinational read data.
REQ-010 SHALL have port wen, input, NR_WR, per-port write enable.
REQ-011 SHALL have port waddr, input, NR_WR*ADDR_WIDTH, packed write addresses.
REQ-012 SHALL have port wdata, input, NR_WR*DATA_WIDTH, packed write data.
REQ-013 SHALL have port ready, output, 1, high once the init sweep completes.

Function
REQ-014 SHALL implement a two-state FSM: INIT and READY.
REQ-015 In INIT, SHALL write zero to entry init_cnt each cycle and increment init_cnt.
REQ-016 SHALL move INIT->READY on the cycle init_cnt == DEPTH-1 is cleared; ready rises the next cycle, DEPTH cycles after rst deassertion.
REQ-017 In INIT, SHALL ignore all wen and drive every rdata to zero.
REQ-018 In READY, SHALL write wdata[j] to entry waddr[j] at posedge when wen[j]=1.
REQ-019 With ZERO_REG=1, writes to entry 0 SHALL be dropped and reads of entry 0 SHALL return zero.
REQ-020 With ZERO_REG=1, init_cnt SHALL still sweep all DEPTH entries.
REQ-021 Multiple write ports hitting one address in a cycle SHALL resolve to the highest-indexed enabled port.
REQ-022 Reads SHALL be combinational; without bypass, a same-cycle write is visible the next cycle.
REQ-023 Distinct-address writes in one cycle SHALL all commit.
REQ-024 READY SHALL be absorbing until rst.

Reset
REQ-025 rst=1 SHALL asynchronously force state=INIT, init_cnt=0, ready=0; array contents undefined until the sweep.
REQ-026 rst asserted mid-sweep or in READY SHALL restart the full sweep from entry 0.

Configuration
REQ-027 With RF_BYPASS_EN defined, in READY a read SHALL return the same-cycle wdata of the winning write port (REQ-021) on address match, except entry 0 when ZERO_REG=1.
REQ-028 Without RF_BYPASS_EN, no bypass logic SHALL exist; REQ-022 applies.

Structure
REQ-029 SHALL place the FSM state enum (RF_INIT, RF_READY) and default width constants in package ysyx_25030081_rf_pkg.
REQ-030 SHALL factor per-read-port match/priority/bypass select into sub-module ysyx_25030081_rf_rdsel, instantiated NR_RD times.

Verification
REQ-031 Release rst: ready=0 for exactly 32 cycles (defaults), then 1; all rdata=0 throughout.
REQ-032 READY, wen[0]=1, waddr=5, wdata=0xDEADBEEF: raddr0=5 reads 0xDEADBEEF next cycle; same cycle old value without bypass, 0xDEADBEEF with RF_BYPASS_EN.
REQ-033 Write 0x1234 to entry 0 (ZERO_REG=1): raddr=0 reads 0.
REQ-034 NR_WR=2, both ports write addr 7 (0x11 port0, 0x22 port1): entry 7 reads 0x22.
REQ-035 Assert rst at sweep cycle 10: ready stays 0 for 32 full cycles after release; prior writes read back 0.
REQ-036 Writes during INIT (wen=1, addr 3, 0xFF) are dropped: entry 3 reads 0 after ready.
